// File: rtl/tinyalu_param.sv
// WIDTH-bit add/and/xor/mul ALU with a registered start/done/busy handshake.
// Optional op 5 (sub) is built only when the TINYALU_SUB_EN macro is defined.
//
//   state  | meaning
//   S_IDLE | ready; single-cycle ops complete here, mul is accepted here
//   S_MUL  | iterative shift-add multiply, MUL_BITS of B per clock
module tinyalu_param #(
  parameter int WIDTH    = 8,
  parameter int MUL_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int N     = WIDTH / MUL_BITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
`ifdef TINYALU_SUB_EN
  localparam logic [2:0] OP_SUB = 3'd5;
`endif

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]     r_b_sh;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_done;
  logic                 r_busy;

  logic [WIDTH:0]       w_sum;
  logic                 w_sc_valid;
  logic [2*WIDTH-1:0]   w_sc_result;
  logic [2*WIDTH-1:0]   w_pp;
  logic [2*WIDTH-1:0]   w_acc_next;
`ifdef TINYALU_SUB_EN
  logic [WIDTH:0]       w_diff;
  assign w_diff = {1'b0, A} - {1'b0, B};
`endif

  assign w_sum = {1'b0, A} + {1'b0, B};

  always_comb begin
    w_sc_valid  = 1'b0;
    w_sc_result = '0;
    case (op)
      OP_ADD: begin
        w_sc_valid  = 1'b1;
        w_sc_result = {{(WIDTH-1){1'b0}}, w_sum};
      end
      OP_AND: begin
        w_sc_valid  = 1'b1;
        w_sc_result = {{WIDTH{1'b0}}, A & B};
      end
      OP_XOR: begin
        w_sc_valid  = 1'b1;
        w_sc_result = {{WIDTH{1'b0}}, A ^ B};
      end
`ifdef TINYALU_SUB_EN
      // Bit WIDTH of the extended difference is the borrow (A < B).
      OP_SUB: begin
        w_sc_valid  = 1'b1;
        w_sc_result = {{(WIDTH-1){1'b0}}, w_diff};
      end
`endif
      default: begin
        w_sc_valid  = 1'b0;
        w_sc_result = '0;
      end
    endcase
  end

  // A is pre-shifted and B consumed from the bottom, so each step needs no variable shifter.
  assign w_pp       = r_a_sh * {{(2*WIDTH-MUL_BITS){1'b0}}, r_b_sh[MUL_BITS-1:0]};
  assign w_acc_next = r_acc + w_pp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              r_a_sh  <= {{WIDTH{1'b0}}, A};
              r_b_sh  <= B;
              r_acc   <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_MUL;
            end else if (w_sc_valid) begin
              r_result <= w_sc_result;
              r_done   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_acc  <= w_acc_next;
          r_a_sh <= r_a_sh << MUL_BITS;
          r_b_sh <= r_b_sh >> MUL_BITS;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_result <= w_acc_next;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_tinyalu_param.sv
// Scoreboard bench for tinyalu_param: WIDTH=8 with MUL_BITS=1 and a second MUL_BITS=4 instance.
// Honours TINYALU_SUB_EN the same way as the design.
module tb_tinyalu_param;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;
  localparam logic [2:0] OP_R7  = 3'd7;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [7:0]  A = 8'd0;
  logic [7:0]  B = 8'd0;
  logic        busy;
  logic        done;
  logic [15:0] result;

  logic        start4 = 1'b0;
  logic [2:0]  op4 = 3'd0;
  logic [7:0]  A4 = 8'd0;
  logic [7:0]  B4 = 8'd0;
  logic        busy4;
  logic        done4;
  logic [15:0] result4;

  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] sb[$];
  logic [15:0] m_exp;

  tinyalu_param #(.WIDTH(8), .MUL_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .result(result)
  );

  tinyalu_param #(.WIDTH(8), .MUL_BITS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .op(op4), .A(A4), .B(B4),
    .busy(busy4), .done(done4), .result(result4)
  );

  always #5 clk = ~clk;

  // Scoreboard: every done on the main instance must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && done === 1'b1) begin
      n_total++;
      if (busy !== 1'b0) $display("FAIL busy_with_done: busy=%0b required 0", busy);
      else n_pass++;
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_done: result=%h with no request pending", result);
      end else begin
        m_exp = sb.pop_front();
        if (result !== m_exp) $display("FAIL sb_result: got %h required %h", result, m_exp);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000)
      $display("FAIL reset_state: busy=%0b done=%0b result=%h required 0/0/0000", busy, done, result);
    else n_pass++;
    n_total++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || result4 !== 16'h0000)
      $display("FAIL reset_state4: busy=%0b done=%0b result=%h required 0/0/0000", busy4, done4, result4);
    else n_pass++;
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    start = 1'b1; op = OP_ADD; A = 8'hFF; B = 8'h01;
    sb.push_back(16'h0100);
    tick();
    start = 1'b0;
    n_total++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== 16'h0100)
      $display("FAIL add_ff_01: done=%0b busy=%0b result=%h required 1/0/0100", done, busy, result);
    else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b0) $display("FAIL add_done_pulse: done=%0b required 0", done);
    else n_pass++;
  endtask

  task automatic test_mul();
    int lat;
    bit busy_ok;
    start = 1'b1; op = OP_MUL; A = 8'hFF; B = 8'hFF;
    sb.push_back(16'hFE01);
    tick();
    start = 1'b0; A = 8'h00; B = 8'h00;
    lat = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
    n_total++;
    if (lat != 8) $display("FAIL mul_latency: got %0d clocks required 8", lat);
    else n_pass++;
    n_total++;
    if (!busy_ok) $display("FAIL mul_busy: busy dropped before done, required high 8 clocks");
    else n_pass++;
    n_total++;
    if (result !== 16'hFE01 || busy !== 1'b0)
      $display("FAIL mul_ff_ff: result=%h busy=%0b required FE01/0", result, busy);
    else n_pass++;
  endtask

  task automatic test_mul_bits4();
    int lat;
    start4 = 1'b1; op4 = OP_MUL; A4 = 8'hFF; B4 = 8'hFF;
    tick();
    start4 = 1'b0;
    n_total++;
    if (busy4 !== 1'b1) $display("FAIL mul4_busy: busy=%0b required 1", busy4);
    else n_pass++;
    lat = 0;
    while (done4 !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    n_total++;
    if (lat != 2) $display("FAIL mul4_latency: got %0d clocks required 2", lat);
    else n_pass++;
    n_total++;
    if (result4 !== 16'hFE01 || busy4 !== 1'b0)
      $display("FAIL mul4_ff_ff: result=%h busy=%0b required FE01/0", result4, busy4);
    else n_pass++;
    tick();
  endtask

  task automatic test_busy_ignore();
    int lat;
    bit extra;
    start = 1'b1; op = OP_MUL; A = 8'h12; B = 8'h34;
    sb.push_back(16'h03A8);
    tick();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (lat == 2) begin
        start = 1'b1; op = OP_ADD; A = 8'h01; B = 8'h01;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    n_total++;
    if (lat != 8 || result !== 16'h03A8)
      $display("FAIL busy_ignore: latency=%0d result=%h required 8/03A8", lat, result);
    else n_pass++;
    extra = 1'b0;
    repeat (3) begin
      tick();
      if (done === 1'b1) extra = 1'b1;
    end
    n_total++;
    if (extra) $display("FAIL busy_ignore_extra_done: done seen after mul, required none");
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    bit extra;
    start = 1'b1; op = OP_MUL; A = 8'hFF; B = 8'h02;
    tick();
    start = 1'b0;
    repeat (3) tick();
    n_total++;
    if (busy !== 1'b1) $display("FAIL mid_mul_busy: busy=%0b required 1", busy);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000)
      $display("FAIL reset_mid_mul: busy=%0b done=%0b result=%h required 0/0/0000", busy, done, result);
    else n_pass++;
    @(posedge clk);
    #1 reset_n = 1'b1;
    extra = 1'b0;
    repeat (12) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) extra = 1'b1;
    end
    n_total++;
    if (extra || result !== 16'h0000)
      $display("FAIL reset_abort: activity after release or result=%h, required idle/0000", result);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    start = 1'b1; op = OP_XOR; A = 8'hA5; B = 8'h0F;
    sb.push_back(16'h00AA);
    tick();
    n_total++;
    if (done !== 1'b1 || result !== 16'h00AA)
      $display("FAIL b2b_xor: done=%0b result=%h required 1/00AA", done, result);
    else n_pass++;
    op = OP_AND; A = 8'hF0; B = 8'h3C;
    sb.push_back(16'h0030);
    tick();
    n_total++;
    if (done !== 1'b1 || result !== 16'h0030)
      $display("FAIL b2b_and: done=%0b result=%h required 1/0030", done, result);
    else n_pass++;
    op = OP_ADD; A = 8'h80; B = 8'h80;
    sb.push_back(16'h0100);
    tick();
    start = 1'b0;
    n_total++;
    if (done !== 1'b1 || result !== 16'h0100)
      $display("FAIL b2b_add: done=%0b result=%h required 1/0100", done, result);
    else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b0) $display("FAIL b2b_end: done=%0b required 0", done);
    else n_pass++;
  endtask

  task automatic test_sub();
    logic [15:0] prev;
    prev = result;
    start = 1'b1; op = OP_SUB; A = 8'h03; B = 8'h05;
`ifdef TINYALU_SUB_EN
    sb.push_back(16'h01FE);
`endif
    tick();
    start = 1'b0;
`ifdef TINYALU_SUB_EN
    n_total++;
    if (done !== 1'b1 || result !== 16'h01FE)
      $display("FAIL sub_03_05: done=%0b result=%h required 1/01FE", done, result);
    else n_pass++;
`else
    n_total++;
    if (done !== 1'b0 || result !== prev)
      $display("FAIL sub_disabled: done=%0b result=%h required 0/%h", done, result, prev);
    else n_pass++;
`endif
    tick();
  endtask

  task automatic test_reserved();
    logic [15:0] prev;
    bit seen;
    prev = result;
    seen = 1'b0;
    start = 1'b1; op = OP_R7; A = 8'h11; B = 8'h22;
    tick();
    if (done === 1'b1) seen = 1'b1;
    op = OP_NOP;
    tick();
    if (done === 1'b1) seen = 1'b1;
    start = 1'b0;
    repeat (2) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    n_total++;
    if (seen || result !== prev)
      $display("FAIL reserved_ops: activity=%0b result=%h required 0/%h", seen, result, prev);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_mul_bits4();
    test_busy_ignore();
    test_reset_mid_mul();
    test_back_to_back();
    test_sub();
    test_reserved();
    repeat (2) tick();
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_drain: %0d results never produced", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
